thermo_gen: RTL
===============

# thermo_gen

Iterative count-to-mask expander: it takes a ones-count and builds a right-aligned word containing exactly that many 1s, inserting one bit per clock. It is the inverse companion of the popcount control/datapath pair. A word produced here and fed to the popcount unit returns the original count, so the two blocks form a loopback pair for self-test. Control is a small FSM in the top module; a register/shift datapath sits beside it.

## Interface
Parameters:
- `WIDTH`, default 16: output word width.
- `CW`, default 5: count width, equal to clog2(WIDTH+1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset; clears all state immediately while low.
- `start`  in  1  request; sampled only in IDLE.
- `count`  in  CW  requested number of 1s; sampled in the same cycle as an accepted `start`.
- `busy`  out  1  high in SHIFT.
- `done`  out  1  one-cycle pulse in DONE.
- `sat`  out  1  high if the last accepted `count` exceeded WIDTH; held until the next accept.
- `resultado`  out  WIDTH  last completed mask; held until the next completion.

## Operation
- Datapath registers:
  - `regA` [WIDTH-1:0]: mask being built.
  - `regB` [CW-1:0]: remaining ones.
  - `res` [WIDTH-1:0]: drives `resultado`.
  - `sat` flag.
- States:
  - IDLE: on `start`=1, set `regA`=0 and `regB`=min(`count`, WIDTH). Set `sat`=(`count`>WIDTH). Go to SHIFT.
  - SHIFT: if `regB`==0, copy `regA` into `res` and go to DONE. Otherwise set `regA`={`regA`[WIDTH-2:0],1'b1}, set `regB`=`regB`-1, and stay in SHIFT.
  - DONE: `done`=1, then unconditionally return to IDLE. `start` is ignored in DONE.
- `start` is ignored in SHIFT and DONE. There is no queueing, and `count` changes while busy have no effect.
- Clamp rule: `count` > WIDTH behaves exactly as `count`=WIDTH, except that `sat` is set.
- Result rule: `resultado` = (1<<N)-1, where N is the clamped count. N=WIDTH gives all ones.
- `resultado` never exposes partial masks. It changes only on the edge that enters DONE.
- Reset (`reset`=0 at any time, including mid-SHIFT):
  - State goes to IDLE.
  - `regA`, `regB`, `res` and `sat` clear to 0.
  - `busy`=0, `done`=0, `resultado`=0.
  - The in-flight request is dropped and no `done` follows.

## Timing
- Edge E0 accepts `start` (IDLE, `start`=1). `busy` is high from after E0 until the state leaves SHIFT.
- For clamped count N, edges E1..EN shift. Edge E(N+1) enters DONE and updates `resultado`.
- `done` is high for exactly one cycle, after E(N+1). Accept-to-`done` latency is N+1 cycles: 1 cycle for N=0, 17 cycles for N=16.
- Earliest next accept is the edge after DONE. Back-to-back throughput is one request per N+3 cycles.
- `busy` and `done` are never high together. Both are combinational decodes of the state register and carry no extra latency.
- `sat` updates at E0.

## Structure
- Package `thermo_gen_pkg` holds:
  - the state enum (IDLE, SHIFT, DONE), 2 bits;
  - WIDTH/CW default constants;
  - a function for the clamped count.
- Sub-module `thermo_gen_po`: the datapath (`regA`, `regB`, `res`, `sat`).
  - Control inputs: `LoadA`, `ShiftL`, `DecB`, `StoreR`.
  - Status outputs: `zeroB`, `satIn`.
- The FSM lives in `thermo_gen` and drives those controls.

## Test plan
- Reset low for 2 cycles, then release. Required: all outputs 0 and state IDLE, with no `done` for 20 cycles with `start`=0.
- `count`=5, one-cycle `start`. Required: `busy` high for 6 cycles, `done` 6 cycles after accept, `resultado`=0x001F, `sat`=0.
- `count`=0. Required: `done` 1 cycle after accept, `resultado`=0x0000. Then `count`=16: `done` 17 cycles after accept, `resultado`=0xFFFF.
- `count`=20. Required: `resultado`=0xFFFF, `sat`=1, latency 17. Then `count`=3: `sat` returns to 0 and `resultado`=0x0007.
- Accept `count`=8, then pulse `start` with `count`=2 on cycles 3 and 9, and hold `start` high in the DONE cycle. Required:
  - exactly one `done`, with `resultado`=0x00FF;
  - a new accept occurs only on the first IDLE cycle.
- Accept `count`=10 after a prior 0x0007 result, then assert `reset` low asynchronously at cycle 4. Required:
  - outputs are 0 immediately;
  - no `done` follows;
  - after release, `count`=1 yields 0x0001.
- Loopback: feed each `resultado` for `count`=0..16 into the popcount unit. Required: the returned count equals the requested count.

Source files
------------

// File: rtl/thermo_gen_pkg.sv
// thermo_gen_pkg: shared states, default sizes and count clamp for thermo_gen
package thermo_gen_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam int WIDTH_DEF = 16;
  localparam int CW_DEF = 5;
  function automatic int clamp_count(input int c, input int w);
    return c > w ? w : c;
  endfunction
endpackage

// File: rtl/thermo_gen_po.sv
// thermo_gen_po: mask datapath; controls LoadA/ShiftL/DecB/StoreR in, zeroB status, sat flag and res mask out
module thermo_gen_po import thermo_gen_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             LoadA,
  input  logic             ShiftL,
  input  logic             DecB,
  input  logic             StoreR,
  input  logic [CW-1:0]    count,
  output logic             zeroB,
  output logic             sat,
  output logic [WIDTH-1:0] res
);
  logic [WIDTH-1:0] reg_a_q, reg_a_d, res_q, res_d;
  logic [CW-1:0] reg_b_q, reg_b_d;
  logic sat_q, sat_d, sat_in;
  assign sat_in = 32'(count) > WIDTH;
  assign zeroB = reg_b_q == '0;
  assign sat = sat_q;
  assign res = res_q;
  always_comb begin
    reg_a_d = LoadA ? '0 : ShiftL ? {reg_a_q[WIDTH-2:0], 1'b1} : reg_a_q;
    reg_b_d = LoadA ? CW'(clamp_count(32'(count), WIDTH)) : DecB ? reg_b_q - 1'b1 : reg_b_q;
    res_d = StoreR ? reg_a_q : res_q;
    sat_d = LoadA ? sat_in : sat_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      reg_a_q <= '0;
      reg_b_q <= '0;
      res_q <= '0;
      sat_q <= 1'b0;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      res_q <= res_d;
      sat_q <= sat_d;
    end
endmodule

// File: rtl/thermo_gen.sv
// thermo_gen: count-to-mask expander; start/count in, busy/done/sat/resultado out
module thermo_gen import thermo_gen_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW = CW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [WIDTH-1:0] resultado
);
  state_t state_q, state_d;
  logic load_a, shift_l, dec_b, store_r, zero_b;
  always_comb begin
    load_a = state_q == IDLE && start;
    shift_l = state_q == SHIFT && !zero_b;
    dec_b = shift_l;
    store_r = state_q == SHIFT && zero_b;
    state_d = load_a ? SHIFT : store_r ? DONE : state_q == DONE ? IDLE : state_q;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  assign busy = state_q == SHIFT;
  assign done = state_q == DONE;
  thermo_gen_po #(.WIDTH(WIDTH), .CW(CW)) u_po (
    .clk(clk),
    .reset(reset),
    .LoadA(load_a),
    .ShiftL(shift_l),
    .DecB(dec_b),
    .StoreR(store_r),
    .count(count),
    .zeroB(zero_b),
    .sat(sat),
    .res(resultado)
  );
endmodule
